// File: rtl/multi_first_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_first_detector_pkg
// Purpose  : Shared types and helpers for the first-signal detector family.
//            The FSM state encoding and the lowest-set-index helper are also
//            used by the downstream arbiter.
// Revision : 1.0 - initial N-channel release
// ============================================================================
package multi_first_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_LOCKED = 2'd2
    } det_state_e;

    // Upper bound on channel count the index helper can scan. Callers
    // zero-extend their vector to this width and truncate the returned index.
    localparam int c_MAX_CH    = 64;
    localparam int c_MAX_IDX_W = 6;

    // Index of the lowest set bit; 0 when the vector is empty. Scanning from
    // the top down lets the last assignment win, so the lowest bit prevails.
    function automatic logic [c_MAX_IDX_W-1:0] lowest_set_idx(
        input logic [c_MAX_CH-1:0] vec
    );
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = c_MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = c_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_first_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_first_detector_if
// Purpose  : Bundles the detector's channel inputs, re-arm strobe and result
//            outputs.
//            master : event source / status reader (drives in_sig, rearm)
//            slave  : the detector (drives y, first_idx, ts, valid, timeout,
//                     armed)
// Revision : 1.0 - initial N-channel release
// ============================================================================
interface multi_first_detector_if #(
    parameter int N_CH = 4,
    parameter int TS_W = 8
);
    localparam int c_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]    in_sig;
    logic               rearm;
    logic [N_CH-1:0]    y;
    logic [c_IDX_W-1:0] first_idx;
    logic [TS_W-1:0]    ts;
    logic               valid;
    logic               timeout;
    logic               armed;

    modport master (
        output in_sig, rearm,
        input  y, first_idx, ts, valid, timeout, armed
    );

    modport slave (
        input  in_sig, rearm,
        output y, first_idx, ts, valid, timeout, armed
    );

endinterface
`default_nettype wire

// File: rtl/multi_first_detector_det_hit_gen.sv
`default_nettype none
// ============================================================================
// Module   : det_hit_gen
// Purpose  : Produces the per-channel hit vector. Level mode passes the inputs
//            straight through; edge mode reports 0->1 transitions against a
//            one-cycle delayed copy.
// Ports    : clk, rst (async, active-low), in_sig[N_CH] in, hit[N_CH] out
// Revision : 1.0 - initial N-channel release
// ============================================================================
module det_hit_gen #(
    parameter int N_CH      = 4,
    parameter int EDGE_MODE = 0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [N_CH-1:0] in_sig,
    output logic      [N_CH-1:0] hit
);

    logic [N_CH-1:0] r_in_q;

    // Cleared by reset so a channel already high at reset release is seen
    // as a rising edge on the first armed cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_q <= '0;
        end else begin
            r_in_q <= in_sig;
        end
    end

    assign hit = (EDGE_MODE != 0) ? (in_sig & ~r_in_q) : in_sig;

endmodule
`default_nettype wire

// File: rtl/multi_first_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_first_detector
// Purpose  : Captures which channel(s) fire first and locks the result, with
//            an optional coincidence window, arrival timestamp, timeout and
//            software re-arm.
// Ports    : clk        clock
//            rst        asynchronous active-low reset
//            bus.slave  in_sig, rearm in; y, first_idx, ts, valid, timeout,
//                       armed out (all registered)
// Revision : 1.0 - initial N-channel release
// ============================================================================
module multi_first_detector
    import multi_first_detector_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int EDGE_MODE = 0,
    parameter int WINDOW    = 0,
    parameter int TS_W      = 8,
    parameter int TIMEOUT   = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    multi_first_detector_if.slave bus
);

    localparam int              c_IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TS_W-1:0] c_TS_MAX   = '1;
    localparam logic            c_TO_EN    = (TIMEOUT != 0);
    localparam logic [TS_W-1:0] c_TO_LAST  = (TIMEOUT > 0) ? TS_W'(TIMEOUT - 1) : '0;
    localparam logic [7:0]      c_WIN_LOAD = (WINDOW > 0) ? 8'(WINDOW - 1) : 8'd0;

    logic [N_CH-1:0]    w_hit;
    logic [c_IDX_W-1:0] w_hit_idx;

    det_state_e         r_state,     w_state_nxt;
    logic [TS_W-1:0]    r_elapsed,   w_elapsed_nxt;
    logic [7:0]         r_win_cnt,   w_win_cnt_nxt;
    logic [N_CH-1:0]    r_y,         w_y_nxt;
    logic [c_IDX_W-1:0] r_first_idx, w_first_idx_nxt;
    logic [TS_W-1:0]    r_ts,        w_ts_nxt;
    logic               r_valid,     w_valid_nxt;
    logic               r_timeout,   w_timeout_nxt;
    logic               r_armed,     w_armed_nxt;

    det_hit_gen #(
        .N_CH      (N_CH),
        .EDGE_MODE (EDGE_MODE)
    ) u_hit_gen (
        .clk    (clk),
        .rst    (rst),
        .in_sig (bus.in_sig),
        .hit    (w_hit)
    );

    assign w_hit_idx = c_IDX_W'(lowest_set_idx(c_MAX_CH'(w_hit)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_elapsed   <= '0;
            r_win_cnt   <= '0;
            r_y         <= '0;
            r_first_idx <= '0;
            r_ts        <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_elapsed   <= w_elapsed_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_y         <= w_y_nxt;
            r_first_idx <= w_first_idx_nxt;
            r_ts        <= w_ts_nxt;
            r_valid     <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_armed     <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        // elapsed only runs while staying armed; every other path leaves it
        // at zero so a re-arm always starts counting from 0.
        w_elapsed_nxt   = '0;
        w_win_cnt_nxt   = r_win_cnt;
        w_y_nxt         = r_y;
        w_first_idx_nxt = r_first_idx;
        w_ts_nxt        = r_ts;
        w_valid_nxt     = r_valid;
        w_timeout_nxt   = r_timeout;

        unique case (r_state)
            ST_IDLE: begin
                w_elapsed_nxt = (r_elapsed == c_TS_MAX) ? r_elapsed : r_elapsed + 1'b1;
                if (|w_hit) begin
                    // A hit takes priority over a timeout in the same cycle.
                    w_y_nxt         = w_hit;
                    w_first_idx_nxt = w_hit_idx;
                    w_ts_nxt        = r_elapsed;
                    w_elapsed_nxt   = '0;
                    if (WINDOW == 0) begin
                        w_state_nxt = ST_LOCKED;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_WINDOW;
                        w_win_cnt_nxt = c_WIN_LOAD;
                    end
                end else if (c_TO_EN && (r_elapsed == c_TO_LAST)) begin
                    w_state_nxt   = ST_LOCKED;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            ST_WINDOW: begin
                // Hits in the final window cycle are still merged.
                w_y_nxt = r_y | w_hit;
                if (r_win_cnt == 8'd0) begin
                    w_state_nxt = ST_LOCKED;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_win_cnt_nxt = r_win_cnt - 8'd1;
                end
            end
            ST_LOCKED: begin
                if (bus.rearm) begin
                    w_state_nxt     = ST_IDLE;
                    w_y_nxt         = '0;
                    w_first_idx_nxt = '0;
                    w_ts_nxt        = '0;
                    w_valid_nxt     = 1'b0;
                    w_timeout_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered from the next state so it always equals (state == IDLE).
    assign w_armed_nxt = (w_state_nxt == ST_IDLE);

    assign bus.y         = r_y;
    assign bus.first_idx = r_first_idx;
    assign bus.ts        = r_ts;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.armed     = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_multi_first_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_first_detector
// Purpose  : Directed self-checking bench. Three detector instances share one
//            clock and reset: d0 (level, WINDOW=0), dw (level, WINDOW=2) and
//            de (edge, TIMEOUT=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_first_detector;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multi_first_detector_if #(.N_CH(4), .TS_W(8)) if0 ();
    multi_first_detector_if #(.N_CH(4), .TS_W(8)) ifw ();
    multi_first_detector_if #(.N_CH(4), .TS_W(8)) ife ();

    multi_first_detector #(
        .N_CH(4), .EDGE_MODE(0), .WINDOW(0), .TS_W(8), .TIMEOUT(0)
    ) u_d0 (.clk(clk), .rst(rst), .bus(if0));

    multi_first_detector #(
        .N_CH(4), .EDGE_MODE(0), .WINDOW(2), .TS_W(8), .TIMEOUT(0)
    ) u_dw (.clk(clk), .rst(rst), .bus(ifw));

    multi_first_detector #(
        .N_CH(4), .EDGE_MODE(1), .WINDOW(0), .TS_W(8), .TIMEOUT(20)
    ) u_de (.clk(clk), .rst(rst), .bus(ife));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        if0.in_sig = 4'b0000; if0.rearm = 1'b0;
        ifw.in_sig = 4'b0000; ifw.rearm = 1'b0;
        ife.in_sig = 4'b0001; ife.rearm = 1'b0;

        // Reset held for two clocks
        tick(); tick();
        chk("rst_y",       32'(if0.y), 32'h0);
        chk("rst_valid",   32'(if0.valid), 32'h0);
        chk("rst_armed",   32'(if0.armed), 32'h1);
        chk("rst_timeout", 32'(if0.timeout), 32'h0);
        chk("rst_ts",      32'(if0.ts), 32'h0);
        chk("rst_idx",     32'(if0.first_idx), 32'h0);
        chk("rst_e_y",     32'(ife.y), 32'h0);
        chk("rst_e_armed", 32'(ife.armed), 32'h1);
        rst = 1'b1;

        // Edge mode: input high at reset release is a rising edge at elapsed 0
        tick();
        chk("e_first_y",     32'(ife.y), 32'h1);
        chk("e_first_valid", 32'(ife.valid), 32'h1);
        chk("e_first_ts",    32'(ife.ts), 32'h0);
        chk("e_first_armed", 32'(ife.armed), 32'h0);
        chk("d0_still_armed", 32'(if0.armed), 32'h1);

        // Single hit at elapsed=5, WINDOW=0
        repeat (4) tick();
        if0.in_sig = 4'b0100;
        tick();
        chk("single_y",     32'(if0.y), 32'h4);
        chk("single_idx",   32'(if0.first_idx), 32'h2);
        chk("single_ts",    32'(if0.ts), 32'h5);
        chk("single_valid", 32'(if0.valid), 32'h1);
        chk("single_armed", 32'(if0.armed), 32'h0);
        if0.in_sig = 4'b1011;
        repeat (3) tick();
        chk("locked_y",     32'(if0.y), 32'h4);
        chk("locked_idx",   32'(if0.first_idx), 32'h2);
        chk("locked_ts",    32'(if0.ts), 32'h5);
        chk("locked_valid", 32'(if0.valid), 32'h1);

        // Re-arm, then a same-cycle race on channels 1 and 2
        if0.in_sig = 4'b0000; if0.rearm = 1'b1;
        tick();
        if0.rearm = 1'b0;
        chk("rearm_armed", 32'(if0.armed), 32'h1);
        chk("rearm_valid", 32'(if0.valid), 32'h0);
        chk("rearm_y",     32'(if0.y), 32'h0);
        if0.in_sig = 4'b0110;
        tick();
        chk("race_y",   32'(if0.y), 32'h6);
        chk("race_idx", 32'(if0.first_idx), 32'h1);
        chk("race_ts",  32'(if0.ts), 32'h0);

        // Rearm and hit in the same cycle: rearm wins, elapsed restarts at 0
        if0.in_sig = 4'b0010; if0.rearm = 1'b1;
        tick();
        if0.rearm = 1'b0; if0.in_sig = 4'b0000;
        chk("rvh_armed", 32'(if0.armed), 32'h1);
        chk("rvh_y",     32'(if0.y), 32'h0);
        chk("rvh_valid", 32'(if0.valid), 32'h0);
        repeat (3) tick();
        if0.in_sig = 4'b0001;
        tick();
        if0.in_sig = 4'b0000;
        chk("rvh_ts",  32'(if0.ts), 32'h3);
        chk("rvh_y2",  32'(if0.y), 32'h1);
        chk("rvh_idx", 32'(if0.first_idx), 32'h0);

        // Coincidence window of 2 on dw; 16 armed cycles have elapsed
        ifw.in_sig = 4'b0001;
        tick();
        chk("win_t0_y",     32'(ifw.y), 32'h1);
        chk("win_t0_valid", 32'(ifw.valid), 32'h0);
        chk("win_t0_armed", 32'(ifw.armed), 32'h0);
        ifw.in_sig = 4'b0000;
        tick();
        chk("win_t1_valid", 32'(ifw.valid), 32'h0);
        ifw.in_sig = 4'b1000;
        tick();
        chk("win_t2_valid", 32'(ifw.valid), 32'h1);
        chk("win_t2_y",     32'(ifw.y), 32'h9);
        chk("win_t2_idx",   32'(ifw.first_idx), 32'h0);
        chk("win_t2_ts",    32'(ifw.ts), 32'd16);
        ifw.in_sig = 4'b0100;
        tick();
        chk("win_t3_y", 32'(ifw.y), 32'h9);
        ifw.in_sig = 4'b0000;

        // Edge mode: input held through rearm gives no capture, then timeout
        ife.rearm = 1'b1;
        tick();
        ife.rearm = 1'b0;
        chk("to_rearm_armed", 32'(ife.armed), 32'h1);
        chk("to_rearm_y",     32'(ife.y), 32'h0);
        repeat (19) tick();
        chk("to_pre_valid", 32'(ife.valid), 32'h0);
        chk("to_pre_armed", 32'(ife.armed), 32'h1);
        tick();
        chk("to_valid",   32'(ife.valid), 32'h1);
        chk("to_timeout", 32'(ife.timeout), 32'h1);
        chk("to_y",       32'(ife.y), 32'h0);
        chk("to_armed",   32'(ife.armed), 32'h0);

        // Rearm, then a genuine 0->1 on channel 3
        ife.rearm = 1'b1; ife.in_sig = 4'b0000;
        tick();
        ife.rearm = 1'b0;
        chk("e_rearm_timeout", 32'(ife.timeout), 32'h0);
        ife.in_sig = 4'b1000;
        tick();
        chk("e_ch3_y",       32'(ife.y), 32'h8);
        chk("e_ch3_idx",     32'(ife.first_idx), 32'h3);
        chk("e_ch3_ts",      32'(ife.ts), 32'h0);
        chk("e_ch3_timeout", 32'(ife.timeout), 32'h0);

        // Hit on the timeout cycle: the hit wins
        ife.rearm = 1'b1;
        tick();
        ife.rearm = 1'b0;
        repeat (19) tick();
        chk("hvt_pre_armed", 32'(ife.armed), 32'h1);
        ife.in_sig = 4'b1010;
        tick();
        chk("hvt_y",       32'(ife.y), 32'h2);
        chk("hvt_idx",     32'(ife.first_idx), 32'h1);
        chk("hvt_ts",      32'(ife.ts), 32'd19);
        chk("hvt_timeout", 32'(ife.timeout), 32'h0);
        chk("hvt_valid",   32'(ife.valid), 32'h1);

        // Asynchronous reset while locked takes effect without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("arst_w_valid", 32'(ifw.valid), 32'h0);
        chk("arst_w_y",     32'(ifw.y), 32'h0);
        chk("arst_w_armed", 32'(ifw.armed), 32'h1);
        chk("arst_e_ts",    32'(ife.ts), 32'h0);
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
